stereo_disparity_search: RTL and testbench
==========================================

STEREO_DISPARITY_SEARCH -- requirements
Module: stereo_disparity_search

Interface
REQ-001 Parameter PIX_W, default 8: pixel width in bits.
REQ-002 Parameter WIN_LEN, default 16: reference window length in pixels; power of two, 2 or more.
REQ-003 Parameter MAX_DISP, default 32: number of candidate disparities, 0..MAX_DISP-1; 2 or more.
REQ-004 Parameter IMG_W, default 320: image row width in pixels; at least WIN_LEN+MAX_DISP.
REQ-005 Parameter CONF_THRESH, default 64: minimum SAD margin (second best minus best) for a confident result.
REQ-006 Derived widths: SAD_W = PIX_W+log2(WIN_LEN); DISP_W = clog2(MAX_DISP); COL_W = clog2(IMG_W).
REQ-007 One clock; reset is synchronous and active-high.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 start  in  1  single-cycle request; sampled only in IDLE.
REQ-011 hint_col  in  COL_W  pupil-derived gaze column.
REQ-012 fetch_col  out  COL_W  first column upstream must stream; valid while busy.
REQ-013 pix_valid  in  1  pixel stream valid.
REQ-014 pix_data  in  PIX_W  pixel value.
REQ-015 pix_ready  out  1  block accepts a pixel.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle result strobe.
REQ-018 depth  out  DISP_W  best disparity; holds until next done.
REQ-019 best_sad  out  SAD_W  SAD of depth; holds until next done.
REQ-020 confident  out  1  result confidence; holds until next done.

Function
REQ-021 The block SHALL use the states IDLE, LOAD_REF, LOAD_SRCH, COMPUTE and DONE.
REQ-022 IDLE with start=1 SHALL go to LOAD_REF and SHALL latch fetch_col = min(hint_col, IMG_W-WIN_LEN-MAX_DISP).
REQ-023 pix_ready SHALL be 1 only in LOAD_REF and LOAD_SRCH; a pixel is accepted when pix_valid and pix_ready are both 1.
REQ-024 The first WIN_LEN accepted pixels SHALL fill ref[0..WIN_LEN-1]; the last one SHALL move the state to LOAD_SRCH.
REQ-025 The next WIN_LEN+MAX_DISP-1 accepted pixels SHALL fill srch[0..]; the last one SHALL move the state to COMPUTE.
REQ-026 Stalls (pix_valid=0) SHALL hold the state and fill indices without limit.
REQ-027 COMPUTE SHALL accumulate one term |ref[i]-srch[i+d]| per cycle, i inner and d outer, taking exactly MAX_DISP*WIN_LEN cycles.
REQ-028 Each accumulation SHALL be exact, unsigned and unsaturated in SAD_W bits.
REQ-029 A completed SAD SHALL replace the best only if strictly smaller, so on ties the lowest disparity wins.
REQ-030 d=0 SHALL unconditionally initialise the best.
REQ-031 The cycle after the final term SHALL be DONE, with done=1 and depth, best_sad and confident updated; the next cycle SHALL be IDLE.
REQ-032 start SHALL be ignored in every state except IDLE.
REQ-033 hint_col changes while busy SHALL have no effect.

Reset
REQ-034 rst=1 SHALL force IDLE from any state, discarding partial loads and sums.
REQ-035 Reset values: pix_ready=0, busy=0, done=0, depth=0, best_sad=0, confident=0, fetch_col=0.
REQ-036 Buffer contents need no reset.

Configuration
REQ-037 Macro DISP_CONF_EN defined: the block SHALL also track the second-smallest SAD and set confident = (second-best_sad >= CONF_THRESH).
REQ-038 Macro DISP_CONF_EN undefined: no second-best logic SHALL exist and confident SHALL equal 1 at every done (0 after reset).

Verification (WIN_LEN=4, MAX_DISP=4, IMG_W=16, PIX_W=8, CONF_THRESH=64)
REQ-039 Scenario: hint_col=3, ref=10,20,30,40, srch=0,0,10,20,30,40,0 -> done 16 cycles after the last load, depth=2, best_sad=0, confident=1.
REQ-040 Scenario: hint_col=15 -> fetch_col=8; hint_col=0 -> fetch_col=0.
REQ-041 Scenario: ref all 5, srch all 5 -> depth=0 on tie, best_sad=0; with DISP_CONF_EN, confident=0.
REQ-042 Scenario: ref all 255, srch all 0 -> best_sad=1020 with no overflow, depth=0.
REQ-043 Scenario: pix_valid deasserted on alternate cycles during both loads -> same result as the unstalled run.
REQ-044 Scenario: rst pulsed mid-COMPUTE, then a second start pulsed during LOAD_REF of a new job -> return to IDLE with no done, and the second start ignored.

Source files
------------

// File: rtl/stereo_disparity_search.sv
// Stereo disparity search: SAD block matching of a WIN_LEN reference window over MAX_DISP shifts.
// Define DISP_CONF_EN to track the second-best SAD and derive a margin-based confidence flag.
module stereo_disparity_search #(
    parameter int unsigned PIX_W       = 8,
    parameter int unsigned WIN_LEN     = 16,
    parameter int unsigned MAX_DISP    = 32,
    parameter int unsigned IMG_W       = 320,
    parameter int unsigned CONF_THRESH = 64,
    localparam int unsigned SAD_W      = PIX_W + $clog2(WIN_LEN),
    localparam int unsigned DISP_W     = $clog2(MAX_DISP),
    localparam int unsigned COL_W      = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [COL_W-1:0]  hint_col,
    output logic [COL_W-1:0]  fetch_col,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    output logic              busy,
    output logic              done,
    output logic [DISP_W-1:0] depth,
    output logic [SAD_W-1:0]  best_sad,
    output logic              confident
);

    localparam int unsigned SRCH_LEN = WIN_LEN + MAX_DISP - 1;
    localparam int unsigned IDX_W    = $clog2(SRCH_LEN);
    localparam int unsigned I_W      = $clog2(WIN_LEN);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - WIN_LEN - MAX_DISP);

    typedef enum logic [2:0] {StIdle, StLoadRef, StLoadSrch, StCompute, StDone} state_e;
    state_e state_q, state_d;

    logic [PIX_W-1:0]  ref_buf  [WIN_LEN];
    logic [PIX_W-1:0]  srch_buf [SRCH_LEN];
    logic [IDX_W-1:0]  fill_q;
    logic [I_W-1:0]    i_q;
    logic [DISP_W-1:0] d_q;
    logic [SAD_W-1:0]  acc_q, cur_sad;
    logic [SAD_W-1:0]  best_q, best_d;
    logic [DISP_W-1:0] best_disp_q, best_disp_d;
    logic [PIX_W-1:0]  pa, pb, diff;
    logic [IDX_W-1:0]  srch_idx;
    logic              accept, ref_last, srch_last, term_last, job_last, conf_d;

    assign accept    = pix_valid && (state_q == StLoadRef || state_q == StLoadSrch);
    assign ref_last  = fill_q == IDX_W'(WIN_LEN - 1);
    assign srch_last = fill_q == IDX_W'(SRCH_LEN - 1);
    assign term_last = i_q == I_W'(WIN_LEN - 1);
    assign job_last  = term_last && (d_q == DISP_W'(MAX_DISP - 1));
    assign srch_idx  = IDX_W'(i_q) + IDX_W'(d_q);

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pix_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) state_d = StLoadRef;
            end
            StLoadRef: begin
                pix_ready = 1'b1;
                if (accept && ref_last) state_d = StLoadSrch;
            end
            StLoadSrch: begin
                pix_ready = 1'b1;
                if (accept && srch_last) state_d = StCompute;
            end
            StCompute: if (job_last) state_d = StDone;
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Absolute difference of the current term and the running best for the completed shift.
    always_comb begin
        pa          = ref_buf[i_q];
        pb          = srch_buf[srch_idx];
        diff        = (pa > pb) ? pa - pb : pb - pa;
        cur_sad     = acc_q + SAD_W'(diff);
        best_d      = best_q;
        best_disp_d = best_disp_q;
        if (d_q == '0) begin
            best_d      = cur_sad;
            best_disp_d = '0;
        end else if (cur_sad < best_q) begin
            best_d      = cur_sad;
            best_disp_d = d_q;
        end
    end

`ifdef DISP_CONF_EN
    logic [SAD_W-1:0] second_q, second_d;

    // Ties with the best land here, giving a zero margin.
    always_comb begin
        second_d = second_q;
        if (d_q == '0)              second_d = '1;
        else if (cur_sad < best_q)  second_d = best_q;
        else if (cur_sad < second_q) second_d = cur_sad;
        conf_d = 32'(second_d - best_d) >= CONF_THRESH;
    end

    always_ff @(posedge clk) begin
        if (rst)                                    second_q <= '0;
        else if (state_q == StCompute && term_last) second_q <= second_d;
    end
`else
    assign conf_d = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q      <= '0;
            i_q         <= '0;
            d_q         <= '0;
            acc_q       <= '0;
            best_q      <= '0;
            best_disp_q <= '0;
            fetch_col   <= '0;
            depth       <= '0;
            best_sad    <= '0;
            confident   <= 1'b0;
        end else begin
            if (state_q == StIdle && start) begin
                fetch_col <= (hint_col > COL_MAX) ? COL_MAX : hint_col;
                fill_q    <= '0;
                i_q       <= '0;
                d_q       <= '0;
                acc_q     <= '0;
            end
            if (accept) begin
                if ((state_q == StLoadRef) ? ref_last : srch_last) fill_q <= '0;
                else                                               fill_q <= fill_q + 1'b1;
            end
            if (state_q == StCompute) begin
                i_q   <= term_last ? '0 : i_q + 1'b1;
                acc_q <= term_last ? '0 : cur_sad;
                if (term_last) begin
                    d_q         <= d_q + 1'b1;
                    best_q      <= best_d;
                    best_disp_q <= best_disp_d;
                end
                if (job_last) begin
                    depth     <= best_disp_d;
                    best_sad  <= best_d;
                    confident <= conf_d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && state_q == StLoadRef)  ref_buf[fill_q[I_W-1:0]] <= pix_data;
        if (accept && state_q == StLoadSrch) srch_buf[fill_q]          <= pix_data;
    end

endmodule

// File: tb/tb_stereo_disparity_search.sv
// Bench for stereo_disparity_search: directed vector table, randomized jobs against a SAD model,
// and reset / ignored-start sequences.
module tb_stereo_disparity_search;

    localparam int WIN  = 4;
    localparam int MAXD = 4;
    localparam int IMGW = 16;
    localparam int SRCH = WIN + MAXD - 1;
    localparam int THR  = 64;

    logic       clk = 1'b0;
    logic       rst, start, pix_valid, pix_ready, busy, done, confident;
    logic [3:0] hint_col, fetch_col;
    logic [7:0] pix_data;
    logic [1:0] depth;
    logic [9:0] best_sad;

    int checks = 0;
    int errors = 0;
    int ref_m  [WIN];
    int srch_m [SRCH];

    typedef struct packed {
        logic [31:0] refs;
        logic [55:0] srchs;
        logic [3:0]  hint;
        logic        stall;
        logic [3:0]  fetch;
        logic [1:0]  depth;
        logic [9:0]  sad;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    stereo_disparity_search #(
        .PIX_W(8), .WIN_LEN(WIN), .MAX_DISP(MAXD), .IMG_W(IMGW), .CONF_THRESH(THR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .hint_col(hint_col), .fetch_col(fetch_col),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready), .busy(busy),
        .done(done), .depth(depth), .best_sad(best_sad), .confident(confident)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Plain SAD over every shift; lowest shift wins ties.
    task automatic model(output int bd, output int bs, output int conf);
        int sads [MAXD];
        int df;
        for (int d = 0; d < MAXD; d++) begin
            sads[d] = 0;
            for (int i = 0; i < WIN; i++) begin
                df = ref_m[i] - srch_m[i + d];
                sads[d] += (df < 0) ? -df : df;
            end
        end
        bd = 0;
        for (int d = 1; d < MAXD; d++) if (sads[d] < sads[bd]) bd = d;
        bs = sads[bd];
`ifdef DISP_CONF_EN
        begin
            int sec;
            sec = 32'h7fffffff;
            for (int d = 0; d < MAXD; d++) if (d != bd && sads[d] < sec) sec = sads[d];
            conf = (sec - bs >= THR) ? 1 : 0;
        end
`else
        conf = 1;
`endif
    endtask

    task automatic load_pixels(input bit stall, input int restart_at, output bit rdy_ok);
        rdy_ok = 1'b1;
        for (int k = 0; k < WIN + SRCH; k++) begin
            if (k == restart_at) begin
                pix_valid = 1'b0;
                start     = 1'b1;
                hint_col  = 4'd0;
                @(negedge clk);
                start = 1'b0;
            end
            if (stall && k[0]) begin
                pix_valid = 1'b0;
                @(negedge clk);
            end
            pix_valid = 1'b1;
            pix_data  = 8'(k < WIN ? ref_m[k] : srch_m[k - WIN]);
            if (pix_ready !== 1'b1) rdy_ok = 1'b0;
            @(negedge clk);
        end
        pix_valid = 1'b0;
    endtask

    task automatic run_job(input string tag, input int gaze, input bit stall, input int restart_at,
                           input int e_fetch, input int e_depth, input int e_sad, input int e_conf);
        bit rdy_ok;
        int cyc;
        start    = 1'b1;
        hint_col = 4'(gaze);
        @(negedge clk);
        start    = 1'b0;
        hint_col = 4'($urandom_range(0, 15));
        check({tag, " busy"}, 32'(busy), 1);
        check({tag, " fetch_col"}, 32'(fetch_col), e_fetch);
        load_pixels(stall, restart_at, rdy_ok);
        check({tag, " pix_ready"}, 32'(rdy_ok), 1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, cyc, MAXD * WIN);
        check({tag, " depth"}, 32'(depth), e_depth);
        check({tag, " best_sad"}, 32'(best_sad), e_sad);
        check({tag, " confident"}, 32'(confident), e_conf);
        check({tag, " fetch_hold"}, 32'(fetch_col), e_fetch);
        @(negedge clk);
        check({tag, " done_clear"}, {30'd0, done, busy}, 0);
        check({tag, " depth_hold"}, 32'(depth), e_depth);
    endtask

    task automatic random_fill(input int hi);
        for (int i = 0; i < WIN; i++)  ref_m[i]  = $urandom_range(0, hi);
        for (int j = 0; j < SRCH; j++) srch_m[j] = $urandom_range(0, hi);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  md, ms, mc, gaze_c;
        bit  rdy_ok, saw_done;

        tbl[0] = '{refs: {8'd40, 8'd30, 8'd20, 8'd10},
                   srchs: {8'd0, 8'd40, 8'd30, 8'd20, 8'd10, 8'd0, 8'd0},
                   hint: 4'd3, stall: 1'b0, fetch: 4'd3, depth: 2'd2, sad: 10'd0};
        tbl[1] = '{refs: {4{8'd5}}, srchs: {7{8'd5}},
                   hint: 4'd15, stall: 1'b0, fetch: 4'd8, depth: 2'd0, sad: 10'd0};
        tbl[2] = '{refs: {4{8'd255}}, srchs: {7{8'd0}},
                   hint: 4'd0, stall: 1'b0, fetch: 4'd0, depth: 2'd0, sad: 10'd1020};
        tbl[3] = '{refs: {8'd40, 8'd30, 8'd20, 8'd10},
                   srchs: {8'd0, 8'd40, 8'd30, 8'd20, 8'd10, 8'd0, 8'd0},
                   hint: 4'd7, stall: 1'b1, fetch: 4'd7, depth: 2'd2, sad: 10'd0};
        tbl[4] = '{refs: {8'd4, 8'd3, 8'd2, 8'd1},
                   srchs: {8'd4, 8'd3, 8'd2, 8'd1, 8'd9, 8'd9, 8'd9},
                   hint: 4'd8, stall: 1'b0, fetch: 4'd8, depth: 2'd3, sad: 10'd0};
        tbl[5] = '{refs: {8'd0, 8'd100, 8'd0, 8'd100},
                   srchs: {8'd0, 8'd100, 8'd0, 8'd100, 8'd0, 8'd100, 8'd0},
                   hint: 4'd9, stall: 1'b1, fetch: 4'd8, depth: 2'd1, sad: 10'd0};

        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = '0; hint_col = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset pix_ready", 32'(pix_ready), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset depth", 32'(depth), 0);
        check("reset best_sad", 32'(best_sad), 0);
        check("reset confident", 32'(confident), 0);
        check("reset fetch_col", 32'(fetch_col), 0);

        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < WIN; i++)  ref_m[i]  = int'(tbl[n].refs[8*i +: 8]);
            for (int j = 0; j < SRCH; j++) srch_m[j] = int'(tbl[n].srchs[8*j +: 8]);
            model(md, ms, mc);
            run_job($sformatf("vec%0d", n), int'(tbl[n].hint), tbl[n].stall, -1,
                    int'(tbl[n].fetch), int'(tbl[n].depth), int'(tbl[n].sad), mc);
        end

        for (int n = 0; n < 24; n++) begin
            random_fill(($urandom_range(0, 1) == 1) ? 3 : 255);
            gaze_c = $urandom_range(0, 15);
            model(md, ms, mc);
            run_job($sformatf("rnd%0d", n), gaze_c, 1'($urandom_range(0, 1)), -1,
                    (gaze_c > 8) ? 8 : gaze_c, md, ms, mc);
        end

        // Reset in the middle of COMPUTE: no result may appear and outputs return to reset values.
        random_fill(255);
        start = 1'b1; hint_col = 4'd6;
        @(negedge clk);
        start = 1'b0;
        load_pixels(1'b0, -1, rdy_ok);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", 32'(busy), 0);
        check("midrst pix_ready", 32'(pix_ready), 0);
        check("midrst depth", 32'(depth), 0);
        check("midrst best_sad", 32'(best_sad), 0);
        check("midrst confident", 32'(confident), 0);
        check("midrst fetch_col", 32'(fetch_col), 0);
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("midrst no_done", 32'(saw_done), 0);

        // Second start during LOAD_REF must not relatch fetch_col or restart the load.
        random_fill(255);
        model(md, ms, mc);
        run_job("restart", 5, 1'b0, 2, 5, md, ms, mc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
